// File: rtl/game_restart_ctrl.sv
// game_restart_ctrl: clears the 9-cell board on a frame boundary after reset
// or after a debounced restart press, then pulses game_start. Rev 1.0
`default_nettype none

module game_restart_ctrl #(
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int CELLS           = 9,
  parameter int ADDR_W          = 4
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              btn_restart,
  input  logic              vsync,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy,
  output logic              game_start,
  output logic              first_player
);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    CLEAR      = 2'd1,
    START      = 2'd2,
    RUN        = 2'd3
  } state_t;

  localparam logic [15:0]       DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic              sync1_q, sync2_q;
  logic              stable_q, stable_d;
  logic              press_q, press_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              vs_prev_q;
  logic              frame_tick;
  state_t            state_q, state_d;
  logic              clr_we_q, clr_we_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              busy_q, busy_d;
  logic              game_start_q, game_start_d;
  logic              first_player_q, first_player_d;

  // A level must differ from the accepted one for DEBOUNCE_CYCLES straight cycles.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == DB_LAST) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  assign frame_tick = vsync & ~vs_prev_q;

  always_comb begin
    state_d        = state_q;
    clr_we_d       = 1'b0;
    clr_addr_d     = '0;
    busy_d         = 1'b1;
    game_start_d   = 1'b0;
    first_player_d = first_player_q;
    unique case (state_q)
      WAIT_FRAME: begin
        if (frame_tick) begin
          state_d  = CLEAR;
          clr_we_d = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_addr_q == LAST_CELL) begin
          state_d      = START;
          game_start_d = 1'b1;
        end else begin
          clr_we_d   = 1'b1;
          clr_addr_d = clr_addr_q + ADDR_ONE;
        end
      end
      START: begin
        state_d = RUN;
        busy_d  = 1'b0;
      end
      RUN: begin
        busy_d = 1'b0;
        if (press_q) begin
          state_d        = WAIT_FRAME;
          busy_d         = 1'b1;
          first_player_d = ~first_player_q;
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      stable_q       <= 1'b0;
      press_q        <= 1'b0;
      cnt_q          <= '0;
      vs_prev_q      <= 1'b1;
      state_q        <= WAIT_FRAME;
      clr_we_q       <= 1'b0;
      clr_addr_q     <= '0;
      busy_q         <= 1'b1;
      game_start_q   <= 1'b0;
      first_player_q <= 1'b0;
    end else begin
      sync1_q        <= btn_restart;
      sync2_q        <= sync1_q;
      stable_q       <= stable_d;
      press_q        <= press_d;
      cnt_q          <= cnt_d;
      vs_prev_q      <= vsync;
      state_q        <= state_d;
      clr_we_q       <= clr_we_d;
      clr_addr_q     <= clr_addr_d;
      busy_q         <= busy_d;
      game_start_q   <= game_start_d;
      first_player_q <= first_player_d;
    end
  end

  assign clr_we       = clr_we_q;
  assign clr_addr     = clr_addr_q;
  assign busy         = busy_q;
  assign game_start   = game_start_q;
  assign first_player = first_player_q;

endmodule

`default_nettype wire
